// File: rtl/route_pkg.sv
// Shared types and widths for the route scheduler.
package route_pkg;

  localparam int NODE_W = 4;
  localparam int DIR_W  = 2;
  localparam int HOPS_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [NODE_W-1:0] node;
    logic              id;
    logic [HOPS_W-1:0] hops;
  } result_t;

endpackage

// File: rtl/route_scheduler_hop_lut.sv
// Combinational next-node function h(k, y); only the low two node bits take part.
module hop_lut
  import route_pkg::*;
(
  input  logic [NODE_W-1:0] node,
  input  logic [DIR_W-1:0]  dir,
  output logic [NODE_W-1:0] next
);

  logic k0, k1, y0, y1;
  logic unused_node_hi;

  assign k0 = node[0];
  assign k1 = node[1];
  assign y0 = dir[0];
  assign y1 = dir[1];
  assign unused_node_hi = ^node[3:2];

  assign next[3] = ((y0 | y1) & k0) | k1;
  assign next[2] = (~k0 & y0) | (k0 & ~y0 & ~y1) | (~k0 & y1) | (k0 & k1);
  assign next[1] = (~y0 & ~y1) | (y0 & y1 & ~k1) | (k0 & k1);
  assign next[0] = (~k1 & ~y0) | (k1 & y1) | (~k0 & ~y0) | (k0 & k1 & y0);

endmodule

// File: rtl/route_scheduler.sv
// Round-robin scheduler sharing one hop_lut between two path-walk requesters.
// Optional hop trace outputs are enabled by defining ROUTE_TRACE_EN.
//
// state | meaning
// IDLE  | waiting for a request, req_ready shows the grant
// WALK  | executing one hop per clock
// DONE  | result presented until res_ready
module route_scheduler
  import route_pkg::*;
#(
  parameter int MAX_HOPS = 8,
  parameter int CNT_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [NODE_W-1:0]     req_src0,
  input  logic [NODE_W-1:0]     req_src1,
  input  logic [2*MAX_HOPS-1:0] req_path0,
  input  logic [2*MAX_HOPS-1:0] req_path1,
  input  logic [CNT_W-1:0]      req_len0,
  input  logic [CNT_W-1:0]      req_len1,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [NODE_W-1:0]     res_node,
  output logic                  res_id,
  output logic [CNT_W-1:0]      res_hops,
  output logic                  busy
`ifdef ROUTE_TRACE_EN
  ,
  output logic                  trace_valid,
  output logic [NODE_W-1:0]     trace_node
`endif
);

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_HOPS);

  state_t state, state_nxt;

  logic [NODE_W-1:0]     cur_node;
  logic [2*MAX_HOPS-1:0] path_q;
  logic                  id_q;
  logic [CNT_W-1:0]      len_q;
  logic [CNT_W-1:0]      hop_cnt;
  logic                  last_grant;

  logic                  gnt_id;
  logic                  accept;
  logic [NODE_W-1:0]     src_sel;
  logic [2*MAX_HOPS-1:0] path_sel;
  logic [CNT_W-1:0]      len_sel;
  logic [CNT_W-1:0]      len_clamped;
  logic [DIR_W-1:0]      dir;
  logic [NODE_W-1:0]     hop_next;
  logic                  last_hop;
  result_t               res;

  // A lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    gnt_id = 1'b0;
    case (req_valid)
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_grant;
      default: gnt_id = 1'b0;
    endcase
  end

  assign accept      = (state == IDLE) && (|req_valid);
  assign req_ready   = accept ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
  assign src_sel     = gnt_id ? req_src1  : req_src0;
  assign path_sel    = gnt_id ? req_path1 : req_path0;
  assign len_sel     = gnt_id ? req_len1  : req_len0;
  assign len_clamped = (len_sel > MAX_LEN) ? MAX_LEN : len_sel;

  assign dir      = path_q[{hop_cnt, 1'b0} +: DIR_W];
  assign last_hop = (hop_cnt == (len_q - CNT_W'(1)));

  hop_lut u_hop_lut (
    .node (cur_node),
    .dir  (dir),
    .next (hop_next)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (len_clamped == '0) ? DONE : WALK;
        end
      end
      WALK: begin
        if (last_hop) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_node   <= '0;
      path_q     <= '0;
      id_q       <= 1'b0;
      len_q      <= '0;
      hop_cnt    <= '0;
      last_grant <= 1'b1;
    end else if (accept) begin
      cur_node   <= src_sel;
      path_q     <= path_sel;
      id_q       <= gnt_id;
      len_q      <= len_clamped;
      hop_cnt    <= '0;
      last_grant <= gnt_id;
    end else if (state == WALK) begin
      cur_node <= hop_next;
      hop_cnt  <= hop_cnt + CNT_W'(1);
    end
  end

  // Result fields read as zero outside DONE so nothing stale leaks out.
  always_comb begin
    res = '0;
    if (state == DONE) begin
      res.node = cur_node;
      res.id   = id_q;
      res.hops = HOPS_W'(hop_cnt);
    end
  end

  assign res_valid = (state == DONE);
  assign res_node  = res.node;
  assign res_id    = res.id;
  assign res_hops  = CNT_W'(res.hops);
  assign busy      = (state != IDLE);

`ifdef ROUTE_TRACE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trace_valid <= 1'b0;
      trace_node  <= '0;
    end else begin
      trace_valid <= (state == WALK);
      if (state == WALK) begin
        trace_node <= hop_next;
      end
    end
  end
`endif

endmodule

// File: tb/tb_route_scheduler.sv
// Directed bench for route_scheduler: vector table plus arbitration, backpressure and reset sequences.
module tb_route_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [3:0]  req_src0 = '0, req_src1 = '0;
  logic [15:0] req_path0 = '0, req_path1 = '0;
  logic [3:0]  req_len0 = '0, req_len1 = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [3:0]  res_node;
  logic        res_id;
  logic [3:0]  res_hops;
  logic        busy;

  int checks = 0;
  int errors = 0;

  route_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_src0  (req_src0),
    .req_src1  (req_src1),
    .req_path0 (req_path0),
    .req_path1 (req_path1),
    .req_len0  (req_len0),
    .req_len1  (req_len1),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_node  (res_node),
    .res_id    (res_id),
    .res_hops  (res_hops),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [3:0]  src;
    logic [15:0] path;
    logic [3:0]  len;
    logic [3:0]  exp_node;
    logic [3:0]  exp_hops;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_req(input logic id, input logic [3:0] src, input logic [15:0] path,
                         input logic [3:0] len);
    if (id) begin
      req_src1 = src; req_path1 = path; req_len1 = len;
    end else begin
      req_src0 = src; req_path0 = path; req_len0 = len;
    end
  endtask

  // Waits for a result, checks it, then acknowledges it for one cycle.
  task automatic wait_res(input logic id, input logic [3:0] node, input logic [3:0] hops,
                          input string tag);
    int n = 0;
    while (!res_valid && n < 30) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, " res_valid"}, int'(res_valid), 1);
    chk({tag, " res_node"}, int'(res_node), int'(node));
    chk({tag, " res_id"}, int'(res_id), int'(id));
    chk({tag, " res_hops"}, int'(res_hops), int'(hops));
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic run_req(input vec_t v, input string tag);
    int n = 0;
    int lat;
    set_req(v.id, v.src, v.path, v.len);
    req_valid[v.id] = 1'b1;
    #1;
    while (!req_ready[v.id] && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, " req_ready"}, int'(req_ready), v.id ? 2 : 1);
    @(posedge clk); #1;
    req_valid[v.id] = 1'b0;
    lat = 1;
    while (!res_valid && lat < 30) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, " latency"}, lat, v.exp_lat);
    chk({tag, " res_node"}, int'(res_node), int'(v.exp_node));
    chk({tag, " res_id"}, int'(res_id), int'(v.id));
    chk({tag, " res_hops"}, int'(res_hops), int'(v.exp_hops));
    chk({tag, " ready_in_done"}, int'(req_ready), 0);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk({tag, " idle_after_ack"}, int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{id: 1'b0, src: 4'd0, path: 16'h0024, len: 4'd3,  exp_node: 4'd15, exp_hops: 4'd3, exp_lat: 4};
    vecs[1] = '{id: 1'b1, src: 4'd2, path: 16'h0003, len: 4'd2,  exp_node: 4'd7,  exp_hops: 4'd2, exp_lat: 3};
    vecs[2] = '{id: 1'b0, src: 4'd9, path: 16'hFFFF, len: 4'd0,  exp_node: 4'd9,  exp_hops: 4'd0, exp_lat: 1};
    vecs[3] = '{id: 1'b1, src: 4'd0, path: 16'h0000, len: 4'd15, exp_node: 4'd14, exp_hops: 4'd8, exp_lat: 9};
    vecs[4] = '{id: 1'b1, src: 4'd5, path: 16'h002D, len: 4'd3,  exp_node: 4'd13, exp_hops: 4'd3, exp_lat: 4};
    vecs[5] = '{id: 1'b0, src: 4'd7, path: 16'h0001, len: 4'd1,  exp_node: 4'd15, exp_hops: 4'd1, exp_lat: 2};

    // Reset state
    #2;
    chk("rst busy", int'(busy), 0);
    chk("rst res_valid", int'(res_valid), 0);
    chk("rst res_node", int'(res_node), 0);
    chk("rst res_hops", int'(res_hops), 0);
    chk("rst req_ready", int'(req_ready), 0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle no req ready", int'(req_ready), 0);

    // Tie out of reset: req0, then waiting req1, then next tie back to req0
    set_req(1'b0, 4'd0, 16'h0024, 4'd3);
    set_req(1'b1, 4'd2, 16'h0003, 4'd2);
    req_valid = 2'b11;
    #1;
    chk("tie1 grant", int'(req_ready), 1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("tie1 busy", int'(busy), 1);
    chk("tie1 ready while walk", int'(req_ready), 0);
    wait_res(1'b0, 4'd15, 4'd3, "tie1 req0");
    chk("loser served next", int'(req_ready), 2);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_res(1'b1, 4'd7, 4'd2, "tie1 req1");
    req_valid = 2'b11;
    #1;
    chk("tie2 grant", int'(req_ready), 1);
    req_valid = 2'b00;
    #1;
    chk("drop before grant", int'(req_ready), 0);
    @(posedge clk); #1;
    chk("drop no state change", int'(busy), 0);

    for (int i = 0; i < 6; i++) begin
      run_req(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result held for 5 cycles, waiting req1 not accepted
    set_req(1'b0, 4'd2, 16'h0003, 4'd2);
    set_req(1'b1, 4'd9, 16'h0000, 4'd0);
    req_valid = 2'b01;
    #1;
    chk("bp grant", int'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 2'b10;
    for (int n = 0; n < 30 && !res_valid; n++) begin
      @(posedge clk); #1;
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp res_valid held", int'(res_valid), 1);
      chk("bp res_node held", int'(res_node), 7);
      chk("bp res_hops held", int'(res_hops), 2);
      chk("bp req_ready low", int'(req_ready), 0);
    end
    res_ready = 1'b1;
    #1;
    chk("bp no accept in done", int'(req_ready), 0);
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("bp res_valid cleared", int'(res_valid), 0);
    chk("bp req1 ready after idle", int'(req_ready), 2);
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("bp len0 lat1 valid", int'(res_valid), 1);
    chk("bp len0 node", int'(res_node), 9);
    chk("bp len0 id", int'(res_id), 1);
    chk("bp len0 hops", int'(res_hops), 0);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;

    // Reset mid-walk
    set_req(1'b0, 4'd0, 16'h0000, 4'd8);
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); @(posedge clk); @(posedge clk); #3;
    chk("pre-reset busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid-walk rst busy", int'(busy), 0);
    chk("mid-walk rst res_valid", int'(res_valid), 0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst hold res_valid", int'(res_valid), 0);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_req(1'b0, 4'd0, 16'h0024, 4'd3);
    set_req(1'b1, 4'd2, 16'h0003, 4'd2);
    req_valid = 2'b11;
    #1;
    chk("post-rst tie grant", int'(req_ready), 1);
    req_valid = 2'b00;
    #1;
    run_req(vecs[4], "post-rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
